dotprod_vec_loader: RTL and testbench
=====================================

// Module: dotprod_vec_loader
// PURPOSE
//  Upstream operand stage for dotprod. Accepts a stream of (a,b) element pairs over a
//  valid/ready handshake and buffers them in two internal arrays. Exposes the element
//  count as n_out, which drives dotprod's n port. Serves dotprod's array reads through a
//  1-cycle-latency read port. The vector is held stable until the consumer releases it
//  with vec_done.
// PARAMETERS
//  DATA_W  32  width of each a/b element
//  DEPTH   16  maximum vector length (elements per bank); power of two, >= 2
//  AW      $clog2(DEPTH)  read/write address width (localparam, derived)
// PORTS
//  sys_clk    in   1       system clock, all logic on rising edge
//  sys_rst    in   1       asynchronous active-high reset
//  s_valid    in   1       input pair valid
//  s_ready    out  1       loader can accept a pair
//  s_a        in   DATA_W  element a[i]
//  s_b        in   DATA_W  element b[i]
//  s_last     in   1       marks final pair of the vector
//  vec_valid  out  1       buffered vector complete and stable
//  n_out      out  32      element count of the buffered vector (to dotprod n)
//  trunc      out  1       sticky: vector was cut at DEPTH without s_last
//  rd_en      in   1       read request
//  rd_addr    in   AW      element index to read
//  rd_a       out  DATA_W  a[rd_addr], registered, valid 1 cycle after rd_en
//  rd_b       out  DATA_W  b[rd_addr], registered, valid 1 cycle after rd_en
//  vec_done   in   1       1-cycle pulse from consumer releasing the vector
// BEHAVIOUR
//  Reset (async, any time, including mid-load or mid-serve):
//   - State -> IDLE; wr_ptr=0; all outputs 0.
//   - Outputs cleared: s_ready, vec_valid, n_out, trunc, rd_a, rd_b.
//   - RAM contents are not cleared; a partial vector is discarded.
//  s_ready is a registered output: 0 in reset, 1 from the first rising edge after
//  reset release. s_ready=1 in IDLE and LOAD, 0 in READY. It never depends
//  combinationally on s_valid.
//  Beat accepted when s_valid && s_ready. Accepted beat writes s_a/s_b at wr_ptr, then
//  wr_ptr increments.
//  FSM:
//   IDLE : accepted beat -> LOAD (or READY if s_last); wr_ptr=1 after the write.
//   LOAD : accepted beats continue.
//          -> READY when an accepted beat has s_last=1, or when the beat at wr_ptr=DEPTH-1
//          is accepted. Cut without s_last sets trunc=1. Later beats up to and including
//          the one with s_last are NOT accepted until the next IDLE.
//   READY: entered with vec_valid=1 and n_out=count (1..DEPTH), both set the same edge
//          s_ready drops.
//          vec_done=1 -> IDLE next edge: vec_valid=0, n_out=0, trunc=0, wr_ptr=0,
//          s_ready=1.
//  vec_done outside READY is ignored. s_valid asserted in the same cycle as vec_done is
//  not accepted (s_ready=0); it is accepted on the following cycle.
//  Read port:
//   - rd_en=1 updates rd_a/rd_b at the next edge.
//   - rd_en=0 holds rd_a/rd_b.
//   - Outside READY, or with rd_addr >= n_out, the read returns 0 on both outputs.
//  Minimum vector length is 1 (a single beat with s_last). No zero-length vector exists.
//  The count never exceeds DEPTH. n_out is zero-extended to 32 bits.
// TESTING
//  1. Reset, then 10 beats a=i+1, b=2*(i+1), s_last on i=9
//     -> vec_valid=1 and n_out=10 one edge after the last beat; s_ready=0; trunc=0.
//  2. In READY, rd_en with rd_addr=3 -> rd_a=4, rd_b=8 one cycle later.
//     rd_addr=12 -> rd_a=rd_b=0.
//  3. DEPTH=16: feed 20 beats with no s_last -> 16 accepted, n_out=16, trunc=1;
//     s_ready=0 for beats 17-20.
//  4. vec_done pulse together with s_valid=1
//     -> that beat is not accepted; next cycle s_ready=1 and the beat loads as element 0.
//  5. Assert sys_rst mid-load after 5 beats
//     -> vec_valid, n_out, s_ready, rd_a and rd_b read 0 immediately.
//     After release, a 3-beat vector gives n_out=3.
//  6. Single beat with s_last -> n_out=1; read addr 0 returns that pair.

Source files
------------

// File: rtl/dotprod_vec_loader_if.sv
// Operand-side bus for the dotprod vector loader: pair stream, vector status,
// consumer read port and release pulse.
interface dotprod_vec_loader_if #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16
);
    localparam int AW = $clog2(DEPTH);

    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_a;
    logic [DATA_W-1:0] s_b;
    logic              s_last;
    logic              vec_valid;
    logic [31:0]       n_out;
    logic              trunc;
    logic              rd_en;
    logic [AW-1:0]     rd_addr;
    logic [DATA_W-1:0] rd_a;
    logic [DATA_W-1:0] rd_b;
    logic              vec_done;

    modport slave (
        input  s_valid, s_a, s_b, s_last, rd_en, rd_addr, vec_done,
        output s_ready, vec_valid, n_out, trunc, rd_a, rd_b
    );

    modport master (
        output s_valid, s_a, s_b, s_last, rd_en, rd_addr, vec_done,
        input  s_ready, vec_valid, n_out, trunc, rd_a, rd_b
    );
endinterface

// File: rtl/dotprod_vec_loader.sv
// Buffers a stream of (a,b) pairs into two banks and holds the completed vector
// for dotprod until released by vec_done.
//
//  state | meaning
//  IDLE  | empty, waiting for the first pair of a vector
//  LOAD  | collecting pairs, wr_ptr = number stored so far
//  READY | vector complete and frozen; reads served, input stalled
module dotprod_vec_loader #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16
) (
    input logic                  sys_clk,
    input logic                  sys_rst,
    dotprod_vec_loader_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        READY = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [31:0]       n_out_q, n_out_d;
    logic              vec_valid_q, vec_valid_d;
    logic              trunc_q, trunc_d;
    logic              s_ready_q, s_ready_d;
    logic [DATA_W-1:0] rd_a_q, rd_b_q;
    logic [DATA_W-1:0] mem_a_q [DEPTH];
    logic [DATA_W-1:0] mem_b_q [DEPTH];
    logic              accept;
    logic              rd_hit;

    assign accept = bus.s_valid && s_ready_q;
    assign rd_hit = (state_q == READY) && ({{(32-AW){1'b0}}, bus.rd_addr} < n_out_q);

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            n_out_q     <= '0;
            vec_valid_q <= 1'b0;
            trunc_q     <= 1'b0;
            s_ready_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            n_out_q     <= n_out_d;
            vec_valid_q <= vec_valid_d;
            trunc_q     <= trunc_d;
            s_ready_q   <= s_ready_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        n_out_d     = n_out_q;
        vec_valid_d = vec_valid_q;
        trunc_d     = trunc_q;
        case (state_q)
            IDLE, LOAD: begin
                if (accept) begin
                    wr_ptr_d = wr_ptr_q + AW'(1);
                    // A full bank closes the vector even without s_last
                    if (bus.s_last || (wr_ptr_q == LAST_PTR)) begin
                        state_d     = READY;
                        vec_valid_d = 1'b1;
                        n_out_d     = {{(32-AW){1'b0}}, wr_ptr_q} + 32'd1;
                        trunc_d     = !bus.s_last;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            READY: begin
                if (bus.vec_done) begin
                    state_d     = IDLE;
                    wr_ptr_d    = '0;
                    n_out_d     = '0;
                    vec_valid_d = 1'b0;
                    trunc_d     = 1'b0;
                end
            end
            default: begin
                state_d     = IDLE;
                wr_ptr_d    = '0;
                n_out_d     = '0;
                vec_valid_d = 1'b0;
                trunc_d     = 1'b0;
            end
        endcase
        s_ready_d = (state_d != READY);
    end

    always_ff @(posedge sys_clk) begin
        if (accept) begin
            mem_a_q[wr_ptr_q] <= bus.s_a;
            mem_b_q[wr_ptr_q] <= bus.s_b;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            rd_a_q <= '0;
            rd_b_q <= '0;
        end else if (bus.rd_en) begin
            rd_a_q <= rd_hit ? mem_a_q[bus.rd_addr] : '0;
            rd_b_q <= rd_hit ? mem_b_q[bus.rd_addr] : '0;
        end
    end

    assign bus.s_ready   = s_ready_q;
    assign bus.vec_valid = vec_valid_q;
    assign bus.n_out     = n_out_q;
    assign bus.trunc     = trunc_q;
    assign bus.rd_a      = rd_a_q;
    assign bus.rd_b      = rd_b_q;
endmodule

// File: tb/tb_dotprod_vec_loader.sv
// Directed and random stimulus for dotprod_vec_loader against a queue-based
// model of the buffered vector.
module tb_dotprod_vec_loader;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 16;
    localparam int AW     = $clog2(DEPTH);

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    dotprod_vec_loader_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    dotprod_vec_loader #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .sys_clk (clk),
        .sys_rst (rst),
        .bus     (bus)
    );

    // Reference: the vector is just two queues plus a "held" flag
    logic [DATA_W-1:0] q_a[$];
    logic [DATA_W-1:0] q_b[$];
    bit                held;
    bit                m_trunc;
    bit                m_ready;
    logic [DATA_W-1:0] m_rd_a;
    logic [DATA_W-1:0] m_rd_b;

    task automatic model_reset();
        q_a.delete();
        q_b.delete();
        held    = 1'b0;
        m_trunc = 1'b0;
        m_ready = 1'b0;
        m_rd_a  = '0;
        m_rd_b  = '0;
    endtask

    task automatic model_edge();
        int addr;
        addr = int'(bus.rd_addr);
        if (bus.rd_en) begin
            if (held && addr < q_a.size()) begin
                m_rd_a = q_a[addr];
                m_rd_b = q_b[addr];
            end else begin
                m_rd_a = '0;
                m_rd_b = '0;
            end
        end
        if (held) begin
            if (bus.vec_done) begin
                q_a.delete();
                q_b.delete();
                held    = 1'b0;
                m_trunc = 1'b0;
            end
        end else if (bus.s_valid && m_ready) begin
            q_a.push_back(bus.s_a);
            q_b.push_back(bus.s_b);
            if (bus.s_last || q_a.size() == DEPTH) begin
                held    = 1'b1;
                m_trunc = !bus.s_last;
            end
        end
        m_ready = !held;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("s_ready",   32'(bus.s_ready),   32'(m_ready));
        chk("vec_valid", 32'(bus.vec_valid), 32'(held));
        chk("n_out",     bus.n_out,          held ? 32'(q_a.size()) : 32'd0);
        chk("trunc",     32'(bus.trunc),     32'(m_trunc));
        chk("rd_a",      bus.rd_a,           m_rd_a);
        chk("rd_b",      bus.rd_b,           m_rd_b);
    endtask

    task automatic cyc(input logic v, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                       input logic last, input logic re, input int addr, input logic done);
        bus.s_valid  = v;
        bus.s_a      = a;
        bus.s_b      = b;
        bus.s_last   = last;
        bus.rd_en    = re;
        bus.rd_addr  = AW'(addr);
        bus.vec_done = done;
        @(posedge clk);
        if (rst) model_reset();
        else     model_edge();
        #1;
        check_all();
    endtask

    task automatic idle_inputs();
        bus.s_valid  = 1'b0;
        bus.s_a      = '0;
        bus.s_b      = '0;
        bus.s_last   = 1'b0;
        bus.rd_en    = 1'b0;
        bus.rd_addr  = '0;
        bus.vec_done = 1'b0;
    endtask

    initial begin
        logic [DATA_W-1:0] xa, xb;
        idle_inputs();
        model_reset();
        #2;
        check_all();
        cyc(0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("s_ready_after_reset", 32'(bus.s_ready), 32'd1);

        // 10-beat vector
        for (int i = 0; i < 10; i++)
            cyc(1, DATA_W'(i + 1), DATA_W'(2 * (i + 1)), (i == 9), 0, 0, 0);
        chk("t1_n_out", bus.n_out, 32'd10);
        chk("t1_vec_valid", 32'(bus.vec_valid), 32'd1);
        chk("t1_s_ready", 32'(bus.s_ready), 32'd0);
        chk("t1_trunc", 32'(bus.trunc), 32'd0);

        cyc(0, 0, 0, 0, 1, 3, 0);
        chk("t2_rd_a_3", bus.rd_a, 32'd4);
        chk("t2_rd_b_3", bus.rd_b, 32'd8);
        cyc(0, 0, 0, 0, 1, 12, 0);
        chk("t2_rd_a_12", bus.rd_a, 32'd0);
        chk("t2_rd_b_12", bus.rd_b, 32'd0);
        cyc(0, 0, 0, 0, 0, 3, 1);

        // 20 beats without s_last: cut at DEPTH
        for (int i = 0; i < 20; i++) begin
            cyc(1, $urandom, $urandom, 0, 0, 0, 0);
            if (i >= 15) chk("t3_stall", 32'(bus.s_ready), 32'd0);
        end
        chk("t3_n_out", bus.n_out, 32'd16);
        chk("t3_trunc", 32'(bus.trunc), 32'd1);
        cyc(0, 0, 0, 0, 1, 15, 0);

        // vec_done together with s_valid
        xa = $urandom;
        xb = $urandom;
        cyc(1, xa, xb, 1, 0, 0, 1);
        chk("t4_ready_after_done", 32'(bus.s_ready), 32'd1);
        chk("t4_not_loaded", 32'(bus.vec_valid), 32'd0);
        cyc(1, xa, xb, 1, 0, 0, 0);
        chk("t4_n_out", bus.n_out, 32'd1);
        cyc(0, 0, 0, 0, 1, 0, 0);
        chk("t4_rd_a0", bus.rd_a, xa);
        chk("t4_rd_b0", bus.rd_b, xb);
        cyc(0, 0, 0, 0, 0, 0, 1);

        // reset in the middle of a load
        for (int i = 0; i < 5; i++)
            cyc(1, $urandom, $urandom, 0, 0, 0, 0);
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        chk("t5_s_ready_rst", 32'(bus.s_ready), 32'd0);
        idle_inputs();
        #2;
        rst = 1'b0;
        cyc(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++)
            cyc(1, $urandom, $urandom, (i == 2), 0, 0, 0);
        chk("t5_n_out", bus.n_out, 32'd3);
        cyc(0, 0, 0, 0, 1, 2, 1);

        // single-beat vector
        xa = $urandom;
        xb = $urandom;
        cyc(1, xa, xb, 1, 0, 0, 0);
        chk("t6_n_out", bus.n_out, 32'd1);
        cyc(0, 0, 0, 0, 1, 0, 0);
        chk("t6_rd_a0", bus.rd_a, xa);
        chk("t6_rd_b0", bus.rd_b, xb);
        cyc(0, 0, 0, 0, 1, 1, 0);
        chk("t6_rd_a1", bus.rd_a, 32'd0);
        cyc(0, 0, 0, 0, 0, 0, 1);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            cyc($urandom_range(0, 3) != 0, $urandom, $urandom, $urandom_range(0, 7) == 0,
                $urandom_range(0, 1) == 1, int'($urandom_range(0, DEPTH - 1)),
                $urandom_range(0, 5) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
